// File: rtl/sysid_checker_if.sv
// ----------------------------------------------------------------------------
// sysid_checker_if
// Avalon-MM read-only bus between the sysid_checker (master) and the
// system-ID slave.
//   avm_address        master->slave  word address: 0 = ID, 1 = timestamp
//   avm_read           master->slave  read request
//   avm_waitrequest    slave->master  stall; request accepted when low
//   avm_readdata       slave->master  32-bit read data
//   avm_readdatavalid  slave->master  qualifies avm_readdata (pipelined)
// ----------------------------------------------------------------------------
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/sysid_checker.sv
// ----------------------------------------------------------------------------
// sysid_checker
// Reads the system-ID word (address 0) and timestamp word (address 1) from
// the system-ID slave after a start pulse, compares them with build-time
// expected values and reports pass/fail/timeout to the boot controller.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   start        one-cycle pulse, honoured only in IDLE or DONE
//   avm          Avalon-MM master port (sysid_checker_if.master)
//   busy         high from the cycle after start until DONE
//   done         high while in DONE
//   pass         id_ok & ts_ok & ~timeout_err, valid while done
//   id_ok/ts_ok  per-word compare results
//   timeout_err  every attempt timed out
//   id_value     captured ID word
//   ts_value     captured timestamp word
//   retry_count  retries consumed in the current run
// ----------------------------------------------------------------------------
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1520803331,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  sysid_checker_if.master      avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout_err,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
  output logic [2:0]           retry_count
);

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    CHECK,
    FLUSH,
    DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RETRY_LIMIT  = 3'(MAX_RETRIES);
  localparam logic [3:0] FLUSH_LAST   = 4'd15;

  state_t     state;
  logic [7:0] tmo_cnt;
  logic [3:0] flush_cnt;

  logic in_req;
  logic in_wait;
  logic accepted;
  logic responded;
  logic tmo_fire;

  // avm_read is registered high for the whole REQ state, so acceptance
  // only depends on waitrequest there.
  always_comb begin
    in_req    = (state == ID_REQ) || (state == TS_REQ);
    in_wait   = (state == ID_WAIT) || (state == TS_WAIT);
    accepted  = in_req && avm.avm_read && !avm.avm_waitrequest;
    responded = in_wait && avm.avm_readdatavalid;
    // The count spans request plus wait of one transaction; a success on
    // the final permitted cycle wins over the timeout.
    tmo_fire  = (in_req || in_wait) && !accepted && !responded &&
                (tmo_cnt == TIMEOUT_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      flush_cnt       <= '0;
      avm.avm_address <= 1'b0;
      avm.avm_read    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout_err     <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
      retry_count     <= '0;
    end else if (tmo_fire) begin
      avm.avm_read <= 1'b0;
      if (retry_count < RETRY_LIMIT) begin
        retry_count <= retry_count + 3'd1;
        flush_cnt   <= '0;
        state       <= FLUSH;
      end else begin
        timeout_err <= 1'b1;
        pass        <= 1'b0;
        done        <= 1'b1;
        busy        <= 1'b0;
        state       <= DONE;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done            <= 1'b0;
            pass            <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout_err     <= 1'b0;
            retry_count     <= '0;
            busy            <= 1'b1;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= 1'b0;
            tmo_cnt         <= '0;
            state           <= ID_REQ;
          end
        end

        ID_REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (accepted) begin
            avm.avm_read <= 1'b0;
            state        <= ID_WAIT;
          end
        end

        ID_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (responded) begin
            id_value        <= avm.avm_readdata;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= 1'b1;
            tmo_cnt         <= '0;
            state           <= TS_REQ;
          end
        end

        TS_REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (accepted) begin
            avm.avm_read <= 1'b0;
            state        <= TS_WAIT;
          end
        end

        TS_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (responded) begin
            ts_value <= avm.avm_readdata;
            state    <= CHECK;
          end
        end

        CHECK: begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
          pass  <= (id_value == EXPECTED_ID) &&
                   (ts_value == EXPECTED_TIMESTAMP);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end

        // Lets any response to the abandoned request drain before the
        // retry; readdatavalid is simply not looked at here.
        FLUSH: begin
          flush_cnt <= flush_cnt + 4'd1;
          if (flush_cnt == FLUSH_LAST) begin
            avm.avm_read    <= 1'b1;
            avm.avm_address <= 1'b0;
            tmo_cnt         <= '0;
            state           <= ID_REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
